// File: rtl/rnd_robin_dispatcher.sv
// rtl/rnd_robin_dispatcher.sv - one-to-many valid/ready dispatcher with rotating one-hot priority token
// A one-entry output buffer holds each beat on its chosen port until that consumer takes it.
module rnd_robin_dispatcher #(
   parameter int PORTS          = 8,
   parameter int DWIDTH         = 32,
   parameter bit SKIP_NOT_READY = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DWIDTH-1:0]          in_data,
   output logic                       in_ready,
   output logic [PORTS-1:0]           out_valid,
   output logic [DWIDTH-1:0]          out_data,
   input  logic [PORTS-1:0]           out_ready,
   output logic [$clog2(PORTS)-1:0]   out_port,
   output logic                       out_port_dv
);

   localparam int PW = $clog2(PORTS);

   logic                 full;
   logic [PORTS-1:0]     token;
   logic                 drain;
   logic                 load;
   logic [2*PORTS-1:0]   dbl;
   logic [2*PORTS-1:0]   dbl_diff;
   logic [2*PORTS-1:0]   dbl_gnt;
   logic [PORTS-1:0]     skip_oh;
   logic [PORTS-1:0]     sel_oh;
   logic [PW-1:0]        sel_idx;

   // The target is frozen while full, so only its own ready can release the beat.
   assign drain    = full & out_ready[out_port];
   assign in_ready = ~full | drain;
   assign load     = in_valid & in_ready;

   // Lowest set bit of the doubled ready vector at or above the token, wrapping via the upper half.
   assign dbl      = {out_ready, out_ready};
   assign dbl_diff = dbl - {{PORTS{1'b0}}, token};
   assign dbl_gnt  = dbl & ~dbl_diff;
   assign skip_oh  = dbl_gnt[PORTS-1:0] | dbl_gnt[2*PORTS-1:PORTS];

   always_comb begin
      sel_oh = token;
      if (SKIP_NOT_READY && (|out_ready))
         sel_oh = skip_oh;
   end

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (sel_oh[i])
            sel_idx = PW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full      <= 1'b0;
         out_valid <= '0;
         out_data  <= '0;
         out_port  <= '0;
         token     <= {{(PORTS-1){1'b0}}, 1'b1};
      end else if (load) begin
         full      <= 1'b1;
         out_valid <= sel_oh;
         out_data  <= in_data;
         out_port  <= sel_idx;
         token     <= {sel_oh[PORTS-2:0], sel_oh[PORTS-1]};
      end else if (drain) begin
         full      <= 1'b0;
         out_valid <= '0;
      end
   end

   assign out_port_dv = full;

endmodule

// File: tb/tb_rnd_robin_dispatcher.sv
// tb/tb_rnd_robin_dispatcher.sv - scoreboard bench for rnd_robin_dispatcher, skip and strict variants
module tb_rnd_robin_dispatcher;

   localparam int P  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          iv    [2];
   logic [DW-1:0] id    [2];
   logic [P-1:0]  ordy  [2];
   logic          irdy  [2];
   logic [P-1:0]  ov    [2];
   logic [DW-1:0] od    [2];
   logic [1:0]    op    [2];
   logic          opdv  [2];

   rnd_robin_dispatcher #(.PORTS(P), .DWIDTH(DW), .SKIP_NOT_READY(1'b1)) u_skip (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_data(id[0]), .in_ready(irdy[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
      .out_port(op[0]), .out_port_dv(opdv[0])
   );

   rnd_robin_dispatcher #(.PORTS(P), .DWIDTH(DW), .SKIP_NOT_READY(1'b0)) u_strict (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_data(id[1]), .in_ready(irdy[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
      .out_port(op[1]), .out_port_dv(opdv[1])
   );

   bit            mfull [2];
   int            mtgt  [2];
   logic [DW-1:0] mdata [2];
   int            mtok  [2];
   logic [33:0]   sb0 [$];
   logic [33:0]   sb1 [$];
   int            passed = 0;
   int            failed = 0;
   int            total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mfull[k] = 1'b0;
         mtgt[k]  = 0;
         mdata[k] = '0;
         mtok[k]  = 0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input logic [P-1:0] r);
      for (int k = 0; k < 2; k++) begin
         iv[k]   = v;
         id[k]   = d;
         ordy[k] = r;
      end
   endtask

   // Called at a negedge with inputs already applied; checks, advances the model, then steps one clock.
   task automatic cyc();
      logic [P-1:0] exp_ov;
      logic [33:0]  e;
      int           s;
      bit           drn;
      bit           ld;
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_ov = '0;
         if (mfull[k]) exp_ov[mtgt[k]] = 1'b1;
         chk($sformatf("in_ready[%0d]", k), irdy[k], (!mfull[k]) || ordy[k][mtgt[k]]);
         chk($sformatf("out_port_dv[%0d]", k), opdv[k], mfull[k]);
         chk($sformatf("out_valid[%0d]", k), ov[k], exp_ov);
         chk($sformatf("out_port[%0d]", k), op[k], mtgt[k]);
         chk($sformatf("out_data[%0d]", k), od[k], mdata[k]);
         if ((ov[k] & ordy[k]) != '0) begin
            chk($sformatf("sb_nonempty[%0d]", k), ((k == 0) ? sb0.size() : sb1.size()) > 0, 1);
            if (((k == 0) ? sb0.size() : sb1.size()) > 0) begin
               e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
               chk($sformatf("sb_beat[%0d]", k), {op[k], od[k]}, e);
            end
         end
         drn = mfull[k] && ordy[k][mtgt[k]];
         ld  = iv[k] && (!mfull[k] || drn);
         if (ld) begin
            s = mtok[k];
            if (k == 0) begin
               for (int j = 0; j < P; j++) begin
                  if (ordy[k][(mtok[k] + j) % P]) begin
                     s = (mtok[k] + j) % P;
                     break;
                  end
               end
            end
            if (k == 0) sb0.push_back({2'(s), id[k]});
            else        sb1.push_back({2'(s), id[k]});
            mfull[k] = 1'b1;
            mtgt[k]  = s;
            mdata[k] = id[k];
            mtok[k]  = (s + 1) % P;
         end else if (drn) begin
            mfull[k] = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // all ready, 8 back-to-back beats rotate 0,1,2,3,0,1,2,3
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'hD000_0000 + i, 4'hF);
         if (i == 1) chk("t1_first_valid", ov[0], 4'b0001);
         cyc();
      end
      drive(1'b0, '0, 4'hF);
      cyc();
      cyc();

      // token moved to port 1, then only ports 0 and 3 ready
      drive(1'b1, 32'hA000_0000, 4'hF);
      cyc();
      drive(1'b0, '0, 4'hF);
      cyc();
      drive(1'b1, 32'hA000_0001, 4'b1001);
      cyc();
      chk("t2_skip_target", op[0], 2'd3);
      drive(1'b1, 32'hA000_0002, 4'b1001);
      cyc();
      chk("t2_wrap_target", op[0], 2'd0);
      drive(1'b0, '0, 4'hF);
      repeat (3) cyc();

      // nothing ready at load: beat parks on the token port and holds
      drive(1'b1, 32'hB000_0000, 4'b0000);
      cyc();
      drive(1'b0, '0, 4'b0000);
      repeat (5) cyc();
      chk("t3_stall_in_ready", irdy[0], 1'b0);
      drive(1'b0, '0, 4'b0100);
      repeat (2) cyc();
      drive(1'b0, '0, 4'hF);
      cyc();
      chk("t3_drained", opdv[0], 1'b0);
      cyc();

      // reset while full clears outputs asynchronously
      drive(1'b1, 32'hC000_0000, 4'b0000);
      cyc();
      drive(1'b0, '0, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t6_rst_valid[%0d]", k), ov[k], 4'b0000);
         chk($sformatf("t6_rst_dv[%0d]", k), opdv[k], 1'b0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'hC000_0001, 4'hF);
      cyc();
      chk("t6_first_port", op[0], 2'd0);
      drive(1'b0, '0, 4'hF);
      repeat (2) cyc();

      // strict rotation: token port 0 not ready, beat must wait there
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'hE000_0000, 4'b0100);
      cyc();
      drive(1'b0, '0, 4'b0100);
      repeat (4) cyc();
      chk("t4_strict_hold", ov[1], 4'b0001);
      drive(1'b0, '0, 4'b0101);
      cyc();
      drive(1'b0, '0, 4'hF);
      repeat (2) cyc();

      // random ready pattern with continuous input
      for (int i = 0; i < 300; i++) begin
         iv[0] = 1'b1;  id[0] = $urandom;  ordy[0] = 4'($urandom_range(0, 15));
         iv[1] = 1'b1;  id[1] = $urandom;  ordy[1] = 4'($urandom_range(0, 15));
         cyc();
      end
      drive(1'b0, '0, 4'hF);
      repeat (3) cyc();
      chk("t5_sb0_empty", sb0.size(), 0);
      chk("t5_sb1_empty", sb1.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
